// File: rtl/pspin_cmd_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pspin_cmd_slot_tracker
// Brief    : Per-core command-slot allocator/tracker. Hands out the lowest
//            free local_cmd_id on issue, retires it on response, and flags
//            responses that do not match an outstanding command.
// Revision : 1.0 - initial release
// ============================================================================
module pspin_cmd_slot_tracker #(
    parameter  int NUM_CORES = 8,
    parameter  int NUM_CMDS  = 4,
    localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int ID_W      = $clog2(NUM_CMDS),
    localparam int CNT_W     = $clog2(NUM_CMDS + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    input  logic [CORE_W-1:0]             issue_core_i,
    output logic                          issue_ready_o,
    output logic [ID_W-1:0]               issue_id_o,
    input  logic                          resp_valid_i,
    input  logic [CORE_W-1:0]             resp_core_i,
    input  logic [ID_W-1:0]               resp_id_i,
    output logic [NUM_CORES-1:0]          done_o,
    output logic [NUM_CORES*NUM_CMDS-1:0] busy_map_o,
    output logic [NUM_CORES*CNT_W-1:0]    occup_o,
    output logic                          idle_o,
    output logic                          err_o
);

    localparam logic [CORE_W:0] c_num_cores = (CORE_W+1)'(NUM_CORES);
    localparam logic [ID_W:0]   c_num_cmds  = (ID_W+1)'(NUM_CMDS);

    logic [NUM_CORES-1:0][NUM_CMDS-1:0] r_busy;
    logic [CNT_W-1:0]                   r_occup [NUM_CORES];
    logic [NUM_CORES-1:0]               r_done;
    logic                               r_err;

    logic                w_issue_core_ok;
    logic                w_resp_core_ok;
    logic                w_resp_id_ok;
    logic [NUM_CMDS-1:0] w_issue_row;
    logic [NUM_CMDS-1:0] w_resp_row;
    logic                w_free_found;
    logic [ID_W-1:0]     w_free_id;
    logic                w_issue_fire;
    logic                w_resp_hit;
    logic                w_resp_bad;
    logic [NUM_CMDS-1:0] w_set_mask;
    logic [NUM_CMDS-1:0] w_clr_mask;

    assign w_issue_core_ok = ({1'b0, issue_core_i} < c_num_cores);
    assign w_resp_core_ok  = ({1'b0, resp_core_i} < c_num_cores);
    assign w_resp_id_ok    = ({1'b0, resp_id_i} < c_num_cmds);

    // An out-of-range core looks fully busy, so it can never be granted.
    assign w_issue_row = w_issue_core_ok ? r_busy[issue_core_i] : '1;
    assign w_resp_row  = w_resp_core_ok  ? r_busy[resp_core_i]  : '0;

    always_comb begin
        w_free_found = 1'b0;
        w_free_id    = '0;
        for (int s = NUM_CMDS - 1; s >= 0; s--) begin
            if (!w_issue_row[s]) begin
                w_free_found = 1'b1;
                w_free_id    = ID_W'(s);
            end
        end
    end

    assign issue_ready_o = w_free_found;
    assign issue_id_o    = w_free_id;

    assign w_issue_fire = issue_valid_i & w_free_found;
    assign w_resp_hit   = resp_valid_i & w_resp_id_ok & w_resp_row[resp_id_i];
    assign w_resp_bad   = resp_valid_i & ~w_resp_hit;

    assign w_set_mask = NUM_CMDS'(1) << w_free_id;
    assign w_clr_mask = NUM_CMDS'(1) << resp_id_i;

    // Issue only ever targets a free slot and a hit response only a busy one,
    // so set and clear never collide on the same bit.
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        logic w_set;
        logic w_clr;

        assign w_set = w_issue_fire & (issue_core_i == CORE_W'(c));
        assign w_clr = w_resp_hit   & (resp_core_i  == CORE_W'(c));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_busy[c]  <= '0;
                r_occup[c] <= '0;
                r_done[c]  <= 1'b0;
            end else begin
                r_busy[c]  <= (r_busy[c] | (w_set ? w_set_mask : '0))
                              & ~(w_clr ? w_clr_mask : '0);
                r_occup[c] <= r_occup[c] + CNT_W'(w_set) - CNT_W'(w_clr);
                r_done[c]  <= w_clr;
            end
        end

        assign occup_o[c*CNT_W +: CNT_W] = r_occup[c];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_resp_bad) begin
            r_err <= 1'b1;
        end
    end

    assign busy_map_o = r_busy;
    assign done_o     = r_done;
    assign idle_o     = ~|r_busy;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pspin_cmd_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pspin_cmd_slot_tracker
// Brief    : Directed vector table plus hand sequences for the slot tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pspin_cmd_slot_tracker;

    localparam int NUM_CORES = 8;
    localparam int NUM_CMDS  = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [2:0]  issue_core_i;
    logic        issue_ready_o;
    logic [1:0]  issue_id_o;
    logic        resp_valid_i;
    logic [2:0]  resp_core_i;
    logic [1:0]  resp_id_i;
    logic [7:0]  done_o;
    logic [31:0] busy_map_o;
    logic [23:0] occup_o;
    logic        idle_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    pspin_cmd_slot_tracker #(
        .NUM_CORES(NUM_CORES),
        .NUM_CMDS (NUM_CMDS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_valid_i(issue_valid_i),
        .issue_core_i (issue_core_i),
        .issue_ready_o(issue_ready_o),
        .issue_id_o   (issue_id_o),
        .resp_valid_i (resp_valid_i),
        .resp_core_i  (resp_core_i),
        .resp_id_i    (resp_id_i),
        .done_o       (done_o),
        .busy_map_o   (busy_map_o),
        .occup_o      (occup_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic       iv;
        logic [2:0] ic;
        logic       rv;
        logic [2:0] rc;
        logic [1:0] rid;
        logic [2:0] wc;
        logic       rdy;
        logic [1:0] id;
        logic [7:0] done;
        logic [3:0] busy;
        logic [2:0] occ;
        logic       idle;
        logic       err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int iv, int ic, int rv, int rc, int rid, int wc,
                                int rdy, int id, int done, int busy, int occ,
                                int idle, int err);
        vec_t v;
        v.iv = 1'(iv);   v.ic = 3'(ic);   v.rv = 1'(rv);   v.rc = 3'(rc);
        v.rid = 2'(rid); v.wc = 3'(wc);   v.rdy = 1'(rdy); v.id = 2'(id);
        v.done = 8'(done); v.busy = 4'(busy); v.occ = 3'(occ);
        v.idle = 1'(idle); v.err = 1'(err);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [2:0] ic,
                         input logic rv, input logic [2:0] rc, input logic [1:0] rid);
        rst_i = rst; issue_valid_i = iv; issue_core_i = ic;
        resp_valid_i = rv; resp_core_i = rc; resp_id_i = rid;
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0);
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_idle", 32'(idle_o), 32'd1);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_busy", busy_map_o, 32'd0);
        check("reset_occup", 32'(occup_o), 32'd0);

        //         iv ic rv rc rid wc rdy id done  busy    occ idle err
        // core 3 fills up, then stays full
        vq.push_back(mk(1, 3, 0, 0, 0, 3, 1, 0, 'h00, 'b0001, 1, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 3, 1, 1, 'h00, 'b0011, 2, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 3, 1, 2, 'h00, 'b0111, 3, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 3, 1, 3, 'h00, 'b1111, 4, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0, 'h00, 'b1111, 4, 0, 0));
        // retire slot 2 on core 3, then reissue it
        vq.push_back(mk(0, 3, 1, 3, 2, 3, 0, 0, 'h08, 'b1011, 3, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 3, 1, 2, 'h00, 'b1111, 4, 0, 0));
        // core 0 full, then same-cycle issue + resp: freed slot not visible yet
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 'h00, 'b0001, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 'h00, 'b0011, 2, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2, 'h00, 'b0111, 3, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3, 'h00, 'b1111, 4, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 'h01, 'b1101, 3, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 'h00, 'b1111, 4, 0, 0));
        // core 1: issue and retire in the same cycle, occupancy unchanged
        vq.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 'h00, 'b0001, 1, 0, 0));
        vq.push_back(mk(1, 1, 1, 1, 0, 1, 1, 1, 'h02, 'b0010, 1, 0, 0));
        // stray response to a free slot on core 5, error stays sticky
        vq.push_back(mk(0, 5, 1, 5, 2, 5, 1, 0, 'h00, 'b0000, 0, 0, 1));
        vq.push_back(mk(1, 5, 0, 0, 0, 5, 1, 0, 'h00, 'b0001, 1, 0, 1));
        // core 3 untouched by the traffic since it refilled
        vq.push_back(mk(0, 3, 0, 0, 0, 3, 0, 0, 'h00, 'b1111, 4, 0, 1));

        foreach (vq[i]) begin
            @(negedge clk_i);
            drive(1'b0, vq[i].iv, vq[i].ic, vq[i].rv, vq[i].rc, vq[i].rid);
            #2;
            check($sformatf("v%0d_ready", i), 32'(issue_ready_o), 32'(vq[i].rdy));
            check($sformatf("v%0d_id", i), 32'(issue_id_o), 32'(vq[i].id));
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_done", i), 32'(done_o), 32'(vq[i].done));
            check($sformatf("v%0d_busy", i), 32'(busy_map_o[vq[i].wc*4 +: 4]), 32'(vq[i].busy));
            check($sformatf("v%0d_occ", i), 32'(occup_o[vq[i].wc*3 +: 3]), 32'(vq[i].occ));
            check($sformatf("v%0d_idle", i), 32'(idle_o), 32'(vq[i].idle));
            check($sformatf("v%0d_err", i), 32'(err_o), 32'(vq[i].err));
        end

        // every core issues two commands from a clean start
        @(negedge clk_i);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0);
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk_i);
                drive(1'b0, 1'b1, 3'(c), 1'b0, 3'd0, 2'd0);
            end
        end
        @(negedge clk_i);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0);
        check("multi_busy", busy_map_o, 32'h3333_3333);
        check("multi_occup", 32'(occup_o), 32'(24'o22222222));
        check("multi_idle", 32'(idle_o), 32'd0);
        check("multi_err", 32'(err_o), 32'd0);

        // make err sticky, then reset wins over a concurrent issue and response
        drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 2'd3);
        @(negedge clk_i);
        check("stray_err", 32'(err_o), 32'd1);
        drive(1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 2'd0);
        @(negedge clk_i);
        check("rst_busy", busy_map_o, 32'd0);
        check("rst_occup", 32'(occup_o), 32'd0);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);

        // a response for a command issued before reset is now stray
        drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 2'd1);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0);
        check("late_err", 32'(err_o), 32'd1);
        check("late_done", 32'(done_o), 32'd0);
        check("late_idle", 32'(idle_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
